vga_fetch_arbiter: RTL and testbench
====================================

Name: vga_fetch_arbiter

Overview:
- Sequences per-line pixel fetches from shared video RAM into the display line buffer, driven by the 640x480@60 timing generator's line-start pulse.
- Shares the single VRAM port with CPU-bus accesses: video fetch has priority, and the CPU is guaranteed a slot after a bounded burst.
- Sits between the VGA timing generator, the line buffer and the VRAM controller.

Parameters:
- ADDR_W, 17, VRAM word address width.
- DATA_W, 32, VRAM word width.
- WORDS_PER_LINE, 80, words fetched per active line.
- LINE_STRIDE, 80, word address increment per line.
- V_ACTIVE, 480, highest line_idx accepted is V_ACTIVE-1.
- BURST_MAX, 4, consecutive fetch grants allowed before a pending CPU request must win.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- line_start  in  1  one-cycle pulse: begin fetching line line_idx
- line_idx  in  10  line to fetch, sampled with line_start
- base_addr  in  ADDR_W  frame base word address, sampled with line_start
- fetch_en  in  1  0 = ignore line_start
- fetch_busy  out  1  line fetch in progress
- fetch_overrun  out  1  one-cycle pulse: line_start arrived while busy
- lb_wr_en  out  1  line buffer write strobe
- lb_wr_addr  out  7  line buffer word index 0..WORDS_PER_LINE-1
- lb_wr_data  out  DATA_W  line buffer write data
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack, held until the next CPU read ack
- mem_req  out  1  VRAM request, held with stable mem_we/addr/wdata until mem_ack
- mem_we  out  1  VRAM write
- mem_addr  out  ADDR_W  VRAM address
- mem_wdata  out  DATA_W  VRAM write data
- mem_ack  in  1  one-cycle completion pulse; earliest the cycle after mem_req rises; read data valid with it
- mem_rdata  in  DATA_W  VRAM read data

Behaviour:
- Reset: all outputs 0; state IDLE; fetch counter 0; burst counter 0; cpu_rdata 0.
- Line start: accepted when fetch_en=1 and line_idx<V_ACTIVE. On acceptance, register line_addr = base_addr + line_idx*LINE_STRIDE (mod 2^ADDR_W, wraps silently), set word count 0 and fetch_busy=1 on the next cycle.
- line_start is ignored (no overrun pulse) when line_idx>=V_ACTIVE or fetch_en=0.
- FSM states: IDLE, FETCH (mem_req for video), CPU (mem_req for CPU).
- Arbitration runs in IDLE, and in the same cycle as mem_ack for back-to-back issue:
  - If fetch pending and (cpu_req=0 or burst_cnt<BURST_MAX): go to FETCH, burst_cnt+1, saturating at BURST_MAX.
  - Else if cpu_req (and no CPU ack in the same cycle): go to CPU, burst_cnt=0.
  - Else: go to IDLE.
- mem_req rises the cycle after the grant decision. Maximum throughput is one word per 2 cycles with 1-cycle ack latency.
- FETCH:
  - mem_we=0, mem_addr=line_addr+word (mod 2^ADDR_W).
  - On mem_ack: lb_wr_en=1 for one cycle the next cycle, with lb_wr_addr=word and lb_wr_data=mem_rdata registered; word+1.
  - After the ack for word WORDS_PER_LINE-1: fetch_busy=0 in the same cycle as the final lb_wr_en.
- CPU:
  - mem_* mirror the CPU request as registered at grant.
  - On mem_ack: cpu_ack=1 the next cycle; on reads, cpu_rdata is updated with that ack.
  - The CPU must drop or change its request after cpu_ack. The arbiter must not re-grant the same cpu_req in the cycle cpu_ack is high.
- Overrun (line_start accepted-qualified while fetch_busy=1):
  - fetch_overrun pulses once.
  - An in-flight FETCH transaction completes; its lb write is suppressed.
  - The new line restarts at word 0 with the new line_addr.
  - An in-flight CPU transaction completes normally.
- line_start in the same cycle as the final fetch ack: treated as overrun-free. The final word is written and the new line starts.
- Asynchronous reset mid-transaction: mem_req drops immediately. The VRAM controller shares the reset, so no dangling ack is expected.
- No combinational path from any input to mem_req; all outputs are registered.

Decomposition:
- Shared package: VRAM ADDR_W/DATA_W constants, V_ACTIVE/H_ACTIVE timing constants (shared with the timing generator), FSM state enum.
- One natural sub-module, vga_fetch_addr_gen: registers line_addr and the word counter, and provides the done flag.

Test Plan:
- Idle CPU: cpu_req read addr 0x00100, mem_ack 1 cycle after mem_req, mem_rdata 0xDEADBEEF -> cpu_ack 1 cycle later, cpu_rdata=0xDEADBEEF, no lb_wr_en.
- Line fetch: base_addr 0x01000, line_idx 2, line_start -> mem_addr 0x010A0..0x010EF sequentially; 80 lb_wr_en pulses with addr 0..79; fetch_busy falls with the last one.
- Contention: cpu_req held during the fetch, BURST_MAX=4 -> exactly 4 fetch grants, then 1 CPU grant, repeating; the CPU is acked within 5 memory transactions.
- Overrun: second line_start after 30 words -> fetch_overrun 1 cycle; the in-flight ack produces no lb write; the next mem_addr is the new line's word 0.
- Edge filtering: line_idx=480 or fetch_en=0 with line_start -> no mem_req, fetch_busy stays 0. base_addr 0x1FFF0 with line 0 -> addresses wrap through 0x1FFFF to 0x00000..0x0003F.
- Async reset asserted while mem_req=1 -> all outputs 0 immediately; after release, a fresh line_start is fetched correctly from word 0.

Source files
------------

// File: rtl/vga_fetch_arbiter_pkg.sv
// Shared constants and types for the VGA line-fetch / VRAM arbitration slice.
//   VRAM_ADDR_W / VRAM_DATA_W : VRAM word address and data widths
//   H_ACTIVE / V_ACTIVE       : 640x480 active-area timing, shared with the timing generator
//   PIX_PER_WORD              : 4bpp pixels packed per 32-bit VRAM word
//   arb_state_t               : VRAM port owner state
package vga_fetch_arbiter_pkg;

  localparam int VRAM_ADDR_W  = 17;
  localparam int VRAM_DATA_W  = 32;
  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int PIX_PER_WORD = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_CPU   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vga_fetch_addr_gen.sv
// Line address / word counter for the video fetch.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : latch a new line (line_addr = base_addr + line_idx*LINE_STRIDE, word = 0)
//   line_idx   : line number to load
//   base_addr  : frame base word address
//   inc        : advance to the next word of the line
//   word       : current word index within the line
//   word_addr  : VRAM address of the current word (wraps modulo 2^ADDR_W)
//   done       : current word is the last one of the line
module vga_fetch_addr_gen
  import vga_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W         = VRAM_ADDR_W,
  parameter int WORDS_PER_LINE = 80,
  parameter int LINE_STRIDE    = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [9:0]        line_idx,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              inc,
  output logic [6:0]        word,
  output logic [ADDR_W-1:0] word_addr,
  output logic              done
);

  logic [ADDR_W-1:0] line_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_addr <= '0;
      word      <= '0;
    end else if (load) begin
      line_addr <= base_addr + ADDR_W'(line_idx) * ADDR_W'(LINE_STRIDE);
      word      <= '0;
    end else if (inc) begin
      word <= word + 7'd1;
    end
  end

  assign word_addr = line_addr + ADDR_W'(word);
  assign done      = (word == 7'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/vga_fetch_arbiter.sv
// Per-line video fetch sequencer sharing one VRAM port with CPU accesses.
// Video fetch has priority; a pending CPU request wins after BURST_MAX
// consecutive fetch grants.
//   clk, rst                 : pixel clock, asynchronous active-high reset
//   line_start/line_idx/base_addr/fetch_en : line fetch request from the timing generator
//   fetch_busy, fetch_overrun: fetch status
//   lb_wr_en/addr/data       : line buffer write port
//   cpu_req/we/addr/wdata, cpu_ack/rdata : CPU access port
//   mem_req/we/addr/wdata, mem_ack/rdata : VRAM controller port
module vga_fetch_arbiter
  import vga_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W         = VRAM_ADDR_W,
  parameter int DATA_W         = VRAM_DATA_W,
  parameter int WORDS_PER_LINE = H_ACTIVE / PIX_PER_WORD,
  parameter int LINE_STRIDE    = 80,
  parameter int V_ACTIVE       = vga_fetch_arbiter_pkg::V_ACTIVE,
  parameter int BURST_MAX      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic [9:0]        line_idx,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              fetch_en,
  output logic              fetch_busy,
  output logic              fetch_overrun,
  output logic              lb_wr_en,
  output logic [6:0]        lb_wr_addr,
  output logic [DATA_W-1:0] lb_wr_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BC_W = $clog2(BURST_MAX + 1);

  arb_state_t        state;
  logic [BC_W-1:0]   burst_cnt;
  logic              suppress;   // outstanding fetch belongs to an abandoned line

  logic              accept, fetch_ack, cpu_done, wr_word, last_ack, overrun;
  logic              fetch_pend, cpu_ok, arb_en, grant_fetch, grant_cpu;
  logic [6:0]        word;
  logic [ADDR_W-1:0] word_addr, next_fetch_addr;
  logic              done;

  vga_fetch_addr_gen #(
    .ADDR_W        (ADDR_W),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .LINE_STRIDE   (LINE_STRIDE)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .line_idx (line_idx),
    .base_addr(base_addr),
    .inc      (wr_word),
    .word     (word),
    .word_addr(word_addr),
    .done     (done)
  );

  always_comb begin
    accept    = line_start && fetch_en && (32'(line_idx) < V_ACTIVE);
    fetch_ack = (state == ST_FETCH) && mem_ack;
    cpu_done  = (state == ST_CPU) && mem_ack;
    wr_word   = fetch_ack && !suppress;
    last_ack  = wr_word && done;
    // A line_start landing on the final ack starts the next line cleanly.
    overrun   = accept && fetch_busy && !last_ack;
    // While a new line is being latched its address is not valid yet, so the
    // next fetch grant waits one cycle.
    fetch_pend = fetch_busy && !accept && !last_ack;
    cpu_ok     = cpu_req && !cpu_ack && !cpu_done;
    arb_en     = (state == ST_IDLE) || mem_ack;
    grant_fetch = arb_en && fetch_pend && (!cpu_ok || (burst_cnt < BC_W'(BURST_MAX)));
    grant_cpu   = arb_en && !grant_fetch && cpu_ok;
    // Granting in the ack cycle: the counter has not advanced yet.
    next_fetch_addr = word_addr + ADDR_W'(wr_word);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      burst_cnt     <= '0;
      suppress      <= 1'b0;
      fetch_busy    <= 1'b0;
      fetch_overrun <= 1'b0;
      lb_wr_en      <= 1'b0;
      lb_wr_addr    <= '0;
      lb_wr_data    <= '0;
      cpu_ack       <= 1'b0;
      cpu_rdata     <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      fetch_overrun <= overrun;
      cpu_ack       <= cpu_done;

      if (accept)        fetch_busy <= 1'b1;
      else if (last_ack) fetch_busy <= 1'b0;

      if (fetch_ack)                          suppress <= 1'b0;
      else if (overrun && state == ST_FETCH)  suppress <= 1'b1;

      lb_wr_en <= wr_word && !overrun;
      if (wr_word) begin
        lb_wr_addr <= word;
        lb_wr_data <= mem_rdata;
      end

      if (cpu_done && !mem_we) cpu_rdata <= mem_rdata;

      if (grant_fetch) begin
        state     <= ST_FETCH;
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= next_fetch_addr;
        mem_wdata <= '0;
        if (burst_cnt < BC_W'(BURST_MAX)) burst_cnt <= burst_cnt + 1'b1;
      end else if (grant_cpu) begin
        state     <= ST_CPU;
        mem_req   <= 1'b1;
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        burst_cnt <= '0;
      end else if (arb_en) begin
        state   <= ST_IDLE;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
module tb_vga_fetch_arbiter;

  localparam int AW   = 17;
  localparam int DW   = 32;
  localparam int LOGN = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          line_start, fetch_en;
  logic [9:0]    line_idx;
  logic [AW-1:0] base_addr;
  logic          fetch_busy, fetch_overrun;
  logic          lb_wr_en;
  logic [6:0]    lb_wr_addr;
  logic [DW-1:0] lb_wr_data;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_fetch_arbiter #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .WORDS_PER_LINE(80),
    .LINE_STRIDE   (80),
    .V_ACTIVE      (480),
    .BURST_MAX     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .line_start   (line_start),
    .line_idx     (line_idx),
    .base_addr    (base_addr),
    .fetch_en     (fetch_en),
    .fetch_busy   (fetch_busy),
    .fetch_overrun(fetch_overrun),
    .lb_wr_en     (lb_wr_en),
    .lb_wr_addr   (lb_wr_addr),
    .lb_wr_data   (lb_wr_data),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  // VRAM contents: fixed pattern derived from the address.
  function automatic logic [31:0] vram_word(input logic [16:0] a);
    if (a == 17'h00100) return 32'hDEADBEEF;
    return 32'hC0DE0000 ^ {15'b0, a};
  endfunction

  // VRAM controller: acks one cycle after each fresh request.
  logic [AW-1:0] wr_addr_seen;
  logic [DW-1:0] wr_data_seen;
  int            wr_seen;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ack      <= 1'b0;
      mem_rdata    <= '0;
      wr_seen      <= 0;
      wr_addr_seen <= '0;
      wr_data_seen <= '0;
    end else begin
      mem_ack <= mem_req && !mem_ack;
      if (mem_req && !mem_ack) begin
        mem_rdata <= vram_word(mem_addr);
        if (mem_we) begin
          wr_addr_seen <= mem_addr;
          wr_data_seen <= mem_wdata;
          wr_seen      <= wr_seen + 1;
        end
      end
    end
  end

  // Activity log sampled just after each rising edge.
  logic [6:0]  lb_a [LOGN];
  logic [31:0] lb_d [LOGN];
  logic        lb_b [LOGN];
  logic [16:0] is_a [LOGN];
  int lb_n = 0, is_n = 0, ovr_n = 0;
  logic prev_req = 1'b0, prev_ack = 1'b0;
  always @(posedge clk) begin
    #1;
    if (lb_wr_en) begin
      if (lb_n < LOGN) begin
        lb_a[lb_n] <= lb_wr_addr;
        lb_d[lb_n] <= lb_wr_data;
        lb_b[lb_n] <= fetch_busy;
      end
      lb_n <= lb_n + 1;
    end
    if (mem_req && (!prev_req || prev_ack)) begin
      if (is_n < LOGN) is_a[is_n] <= mem_addr;
      is_n <= is_n + 1;
    end
    if (fetch_overrun) ovr_n <= ovr_n + 1;
    prev_req <= mem_req;
    prev_ack <= mem_ack;
  end

  task automatic test_reset;
    rst = 1'b1; line_start = 1'b0; fetch_en = 1'b0; line_idx = '0; base_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    total++; if ({fetch_busy, fetch_overrun, lb_wr_en, cpu_ack, mem_req, mem_we} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000",
                      {fetch_busy, fetch_overrun, lb_wr_en, cpu_ack, mem_req, mem_we});
    end
    total++; if ({lb_wr_addr, lb_wr_data, cpu_rdata} !== '0) begin
      bad++; $display("FAIL reset_data: lb_addr=%h lb_data=%h cpu_rdata=%h want 0", lb_wr_addr, lb_wr_data, cpu_rdata);
    end
    total++; if ({mem_addr, mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_mem: addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({mem_req, fetch_busy} !== 2'b00) begin
      bad++; $display("FAIL reset_release: req/busy=%b want 00", {mem_req, fetch_busy});
    end
  endtask

  task automatic test_cpu_idle;
    int n, b_lb, b_wr;
    b_lb = lb_n; b_wr = wr_seen;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00100;
    n = 0;
    while (!cpu_ack && n < 20) begin @(negedge clk); n++; end
    total++; if (n != 3) begin bad++; $display("FAIL cpu_rd_latency: got %0d cycles want 3", n); end
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_rdata: got %h want deadbeef", cpu_rdata); end
    total++; if (is_a[is_n-1] !== 17'h00100) begin bad++; $display("FAIL cpu_rd_addr: got %h want 00100", is_a[is_n-1]); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL cpu_no_regrant_ackcycle: mem_req=%b want 0", mem_req); end
    @(negedge clk);
    total++; if ({cpu_ack, mem_req} !== 2'b00) begin
      bad++; $display("FAIL cpu_ack_pulse: ack/req=%b want 00", {cpu_ack, mem_req});
    end
    cpu_req = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00200; cpu_wdata = 32'h12345678;
    n = 0;
    while (!cpu_ack && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    total++; if (wr_seen - b_wr != 1) begin bad++; $display("FAIL cpu_wr_count: got %0d want 1", wr_seen - b_wr); end
    total++; if ({wr_addr_seen, wr_data_seen} !== {17'h00200, 32'h12345678}) begin
      bad++; $display("FAIL cpu_wr: addr=%h data=%h want 00200 12345678", wr_addr_seen, wr_data_seen);
    end
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_rdata_hold: got %h want deadbeef", cpu_rdata); end
    total++; if (lb_n != b_lb) begin bad++; $display("FAIL cpu_no_lb: got %0d writes want 0", lb_n - b_lb); end
  endtask

  task automatic test_line_fetch(input logic [16:0] base, input logic [9:0] idx, input logic [16:0] a0);
    int n, b_lb, b_is;
    logic [16:0] ea;
    b_lb = lb_n; b_is = is_n;
    base_addr = base; line_idx = idx; fetch_en = 1'b1; line_start = 1'b1;
    @(negedge clk);
    n = 1; line_start = 1'b0;
    total++; if (fetch_busy !== 1'b1) begin bad++; $display("FAIL line_busy_rise: got %b want 1", fetch_busy); end
    while (fetch_busy && n < 400) begin @(negedge clk); n++; end
    total++; if (n != 162) begin bad++; $display("FAIL line_duration: got %0d cycles want 162", n); end
    total++; if (lb_n - b_lb != 80) begin bad++; $display("FAIL line_lb_count: got %0d want 80", lb_n - b_lb); end
    total++; if (is_n - b_is != 80) begin bad++; $display("FAIL line_issue_count: got %0d want 80", is_n - b_is); end
    for (int i = 0; i < 80; i++) begin
      ea = a0 + 17'(i);
      total++; if (is_a[b_is+i] !== ea) begin bad++; $display("FAIL line_mem_addr[%0d]: got %h want %h", i, is_a[b_is+i], ea); end
      total++; if (lb_a[b_lb+i] !== 7'(i) || lb_d[b_lb+i] !== vram_word(ea)) begin
        bad++; $display("FAIL line_lb[%0d]: got %0d/%h want %0d/%h", i, lb_a[b_lb+i], lb_d[b_lb+i], i, vram_word(ea));
      end
    end
    total++; if ({lb_b[b_lb+78], lb_b[b_lb+79]} !== 2'b10) begin
      bad++; $display("FAIL line_busy_fall: busy at writes 78/79 = %b want 10", {lb_b[b_lb+78], lb_b[b_lb+79]});
    end
  endtask

  task automatic test_contention;
    int n, acks, b_lb, b_is, k, f;
    logic [16:0] ea;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h15000;
    n = 0;
    while (!cpu_ack && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    b_lb = lb_n; b_is = is_n; acks = 0;
    base_addr = 17'h0; line_idx = 10'd5; fetch_en = 1'b1; line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0; cpu_req = 1'b1; cpu_addr = 17'h15001;
    n = 0;
    while (fetch_busy && n < 600) begin
      @(negedge clk); n++;
      if (cpu_ack) begin acks++; cpu_addr = cpu_addr + 17'd1; end
    end
    n = 0;
    while (!cpu_ack && n < 20) begin @(negedge clk); n++; end
    if (cpu_ack) acks++;
    @(negedge clk);
    cpu_req = 1'b0;
    total++; if (acks != 20) begin bad++; $display("FAIL cont_cpu_acks: got %0d want 20", acks); end
    total++; if (is_n - b_is != 100) begin bad++; $display("FAIL cont_issue_count: got %0d want 100", is_n - b_is); end
    total++; if (lb_n - b_lb != 80) begin bad++; $display("FAIL cont_lb_count: got %0d want 80", lb_n - b_lb); end
    for (int j = 0; j < 100; j++) begin
      k = j / 5; f = k * 4 + j % 5;
      ea = (j % 5 == 4) ? 17'h15001 + 17'(k) : 17'h00190 + 17'(f);
      total++; if (is_a[b_is+j] !== ea) begin bad++; $display("FAIL cont_grant[%0d]: got %h want %h", j, is_a[b_is+j], ea); end
    end
  endtask

  task automatic test_overrun;
    int n, b_lb, b_is, b_ov;
    logic [16:0] ea;
    b_lb = lb_n; b_is = is_n; b_ov = ovr_n;
    base_addr = 17'h0; line_idx = 10'd10; fetch_en = 1'b1; line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    n = 0;
    while (lb_n - b_lb < 30 && n < 200) begin @(negedge clk); n++; end
    total++; if (lb_n - b_lb != 30) begin bad++; $display("FAIL ovr_setup: got %0d writes want 30", lb_n - b_lb); end
    line_idx = 10'd20; line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    total++; if (fetch_overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse: got %b want 1", fetch_overrun); end
    @(negedge clk);
    total++; if (fetch_overrun !== 1'b0) begin bad++; $display("FAIL ovr_pulse_end: got %b want 0", fetch_overrun); end
    n = 0;
    while (fetch_busy && n < 400) begin @(negedge clk); n++; end
    total++; if (ovr_n - b_ov != 1) begin bad++; $display("FAIL ovr_count: got %0d want 1", ovr_n - b_ov); end
    total++; if (lb_n - b_lb != 110) begin bad++; $display("FAIL ovr_lb_count: got %0d want 110", lb_n - b_lb); end
    total++; if (is_n - b_is != 111) begin bad++; $display("FAIL ovr_issue_count: got %0d want 111", is_n - b_is); end
    total++; if (is_a[b_is+30] !== 17'h0033E) begin bad++; $display("FAIL ovr_inflight_addr: got %h want 0033e", is_a[b_is+30]); end
    total++; if (is_a[b_is+31] !== 17'h00640) begin bad++; $display("FAIL ovr_restart_addr: got %h want 00640", is_a[b_is+31]); end
    total++; if (lb_a[b_lb+29] !== 7'd29 || lb_d[b_lb+29] !== vram_word(17'h0033D)) begin
      bad++; $display("FAIL ovr_last_old: got %0d/%h want 29/%h", lb_a[b_lb+29], lb_d[b_lb+29], vram_word(17'h0033D));
    end
    for (int i = 0; i < 80; i++) begin
      ea = 17'h00640 + 17'(i);
      total++; if (lb_a[b_lb+30+i] !== 7'(i) || lb_d[b_lb+30+i] !== vram_word(ea)) begin
        bad++; $display("FAIL ovr_new_lb[%0d]: got %0d/%h want %0d/%h", i, lb_a[b_lb+30+i], lb_d[b_lb+30+i], i, vram_word(ea));
      end
    end
  endtask

  task automatic test_filter;
    int n, b_lb, b_is, b_ov;
    logic seen;
    b_is = is_n; b_ov = ovr_n; seen = 1'b0;
    base_addr = 17'h0; line_idx = 10'd480; fetch_en = 1'b1; line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    repeat (6) begin @(negedge clk); if (fetch_busy || mem_req) seen = 1'b1; end
    total++; if (seen !== 1'b0 || is_n != b_is) begin bad++; $display("FAIL filter_idx480: activity=%b issues=%0d want 0", seen, is_n - b_is); end
    line_idx = 10'd3; fetch_en = 1'b0; line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0; fetch_en = 1'b1;
    repeat (6) begin @(negedge clk); if (fetch_busy || mem_req) seen = 1'b1; end
    total++; if (seen !== 1'b0 || is_n != b_is) begin bad++; $display("FAIL filter_en0: activity=%b issues=%0d want 0", seen, is_n - b_is); end
    b_lb = lb_n;
    line_idx = 10'd479; line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    repeat (20) @(negedge clk);
    line_idx = 10'd480; line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    n = 0;
    while (fetch_busy && n < 400) begin @(negedge clk); n++; end
    total++; if (is_a[b_is] !== 17'h095B0) begin bad++; $display("FAIL filter_idx479_addr: got %h want 095b0", is_a[b_is]); end
    total++; if (lb_n - b_lb != 80) begin bad++; $display("FAIL filter_busy_ignore_lb: got %0d want 80", lb_n - b_lb); end
    total++; if (ovr_n != b_ov) begin bad++; $display("FAIL filter_no_overrun: got %0d pulses want 0", ovr_n - b_ov); end
    test_line_fetch(17'h1FFF0, 10'd0, 17'h1FFF0);
  endtask

  task automatic test_async_reset;
    int n, b_lb;
    b_lb = lb_n;
    base_addr = 17'h00100; line_idx = 10'd1; fetch_en = 1'b1; line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    n = 0;
    while (lb_n - b_lb < 3 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #2;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL arst_setup: mem_req=%b want 1", mem_req); end
    rst = 1'b1;
    #1;
    total++; if ({mem_req, fetch_busy, lb_wr_en, cpu_ack, fetch_overrun, mem_we} !== 6'b0) begin
      bad++; $display("FAIL arst_flags: got %b want 000000", {mem_req, fetch_busy, lb_wr_en, cpu_ack, fetch_overrun, mem_we});
    end
    total++; if ({mem_addr, lb_wr_addr, lb_wr_data, cpu_rdata} !== '0) begin
      bad++; $display("FAIL arst_data: mem_addr=%h lb=%h/%h cpu_rdata=%h want 0", mem_addr, lb_wr_addr, lb_wr_data, cpu_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_line_fetch(17'h02000, 10'd1, 17'h02050);
  endtask

  initial begin
    test_reset;
    test_cpu_idle;
    test_line_fetch(17'h01000, 10'd2, 17'h010A0);
    test_contention;
    test_overrun;
    test_filter;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
